// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory stage: op encodings, FSM states,
// byte-strobe size masks and the access classification/alignment rules.
package mem_pkg;

  localparam int XLEN = 64;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LD   = 4'd4,
    OP_LBU  = 4'd5,
    OP_LHU  = 4'd6,
    OP_LWU  = 4'd7,
    OP_SB   = 4'd8,
    OP_SH   = 4'd9,
    OP_SW   = 4'd10,
    OP_SD   = 4'd11
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  function automatic logic is_load(mem_op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
  endfunction

  function automatic logic is_store(mem_op_t op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
  endfunction

  function automatic logic [7:0] size_mask(mem_op_t op);
    logic [7:0] m;
    case (op)
      OP_LB, OP_LBU, OP_SB: m = MASK_B;
      OP_LH, OP_LHU, OP_SH: m = MASK_H;
      OP_LW, OP_LWU, OP_SW: m = MASK_W;
      default:              m = MASK_D;
    endcase
    return m;
  endfunction

  // Offset bits that must be zero for an access of this size.
  function automatic logic is_misaligned(mem_op_t op, logic [2:0] offset);
    logic [2:0] align_bits;
    case (op)
      OP_LB, OP_LBU, OP_SB: align_bits = 3'b000;
      OP_LH, OP_LHU, OP_SH: align_bits = 3'b001;
      OP_LW, OP_LWU, OP_SW: align_bits = 3'b011;
      default:              align_bits = 3'b111;
    endcase
    return (is_load(op) || is_store(op)) && ((offset & align_bits) != 3'b000);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Handshake and bus bundle around the memory stage: execute-side input,
// data-bus request/response and register-file writeback.
interface mem_stage_if;
  import mem_pkg::*;

  logic            in_valid;
  logic            in_ready;
  mem_op_t         in_op;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_result;
  logic [XLEN-1:0] in_store_data;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_we;
  logic [XLEN-1:0] mem_req_wdata;
  logic [7:0]      mem_req_strb;

  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            misalign_err;

  modport slave (
    input  in_valid, in_op, in_rd, in_result, in_store_data,
    output in_ready,
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_strb,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output wb_valid, wb_rd, wb_data, misalign_err
  );

  modport master (
    output in_valid, in_op, in_rd, in_result, in_store_data,
    input  in_ready,
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_strb,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  wb_valid, wb_rd, wb_data, misalign_err
  );

endinterface

// File: rtl/load_align.sv
// Picks the loaded bytes out of a returned doubleword and sign/zero extends
// them according to the load op.
module load_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] i_data,
  input  logic [2:0]      i_offset,
  input  mem_op_t         i_op,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = i_data >> {i_offset, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_op)
      OP_LB:  o_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      OP_LH:  o_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      OP_LW:  o_data = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      OP_LBU: o_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      OP_LHU: o_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      OP_LWU: o_data = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: accepts one op at a time, issues a single data-bus
// request for loads/stores and produces a one-cycle writeback pulse.
//
// state   | meaning
// IDLE    | ready for a new op from execute
// REQ     | bus request presented, waiting for mem_req_ready
// RESP    | load issued, waiting for mem_rsp_valid
// WB      | one-cycle writeback of the result
module mem_stage
  import mem_pkg::*;
(
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave bus
);

  state_t          r_state;
  mem_op_t         r_op;
  logic [4:0]      r_rd;
  logic [2:0]      r_offset;

  logic            r_req_valid;
  logic [XLEN-1:0] r_req_addr;
  logic            r_req_we;
  logic [XLEN-1:0] r_req_wdata;
  logic [7:0]      r_req_strb;

  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_misalign;

  logic [2:0]      w_in_offset;
  logic [XLEN-1:0] w_load_data;

  assign w_in_offset = bus.in_result[2:0];

  // Fed straight from the bus so the extended value is registered on the
  // same edge that captures the response.
  load_align u_load_align (
    .i_data   (bus.mem_rsp_data),
    .i_offset (r_offset),
    .i_op     (r_op),
    .o_data   (w_load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NONE;
      r_rd        <= '0;
      r_offset    <= '0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_we    <= 1'b0;
      r_req_wdata <= '0;
      r_req_strb  <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_misalign <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_op     <= bus.in_op;
            r_rd     <= bus.in_rd;
            r_offset <= w_in_offset;
            if (is_misaligned(bus.in_op, w_in_offset)) begin
              r_misalign <= 1'b1;
            end else if (is_load(bus.in_op) || is_store(bus.in_op)) begin
              r_state     <= ST_REQ;
              r_req_valid <= 1'b1;
              r_req_addr  <= {bus.in_result[XLEN-1:3], 3'b000};
              r_req_we    <= is_store(bus.in_op);
              if (is_store(bus.in_op)) begin
                r_req_wdata <= bus.in_store_data << {w_in_offset, 3'b000};
                r_req_strb  <= size_mask(bus.in_op) << w_in_offset;
              end else begin
                r_req_wdata <= '0;
                r_req_strb  <= '0;
              end
            end else begin
              r_state    <= ST_WB;
              r_wb_valid <= (bus.in_rd != 5'd0);
              r_wb_rd    <= bus.in_rd;
              r_wb_data  <= bus.in_result;
            end
          end
        end

        ST_REQ: begin
          if (bus.mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_we    <= 1'b0;
            r_req_wdata <= '0;
            r_req_strb  <= '0;
            r_state     <= is_store(r_op) ? ST_IDLE : ST_RESP;
          end
        end

        ST_RESP: begin
          if (bus.mem_rsp_valid) begin
            r_state    <= ST_WB;
            r_wb_valid <= (r_rd != 5'd0);
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_load_data;
          end
        end

        ST_WB: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready      = (r_state == ST_IDLE);
  assign bus.mem_req_valid = r_req_valid;
  assign bus.mem_req_addr  = r_req_addr;
  assign bus.mem_req_we    = r_req_we;
  assign bus.mem_req_wdata = r_req_wdata;
  assign bus.mem_req_strb  = r_req_strb;
  assign bus.wb_valid      = r_wb_valid;
  assign bus.wb_rd         = r_wb_rd;
  assign bus.wb_data       = r_wb_data;
  assign bus.misalign_err  = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// ops, each compared against a byte-level reference model.
module tb_mem_stage;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_stage_if bus ();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size, signedness, byte gather and lane placement.
  function automatic int ref_bytes(mem_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_LWU, OP_SW: return 4;
      default:              return 8;
    endcase
  endfunction

  function automatic bit ref_is_load(mem_op_t op);
    return (op >= OP_LB) && (op <= OP_LWU);
  endfunction

  function automatic bit ref_is_store(mem_op_t op);
    return (op >= OP_SB) && (op <= OP_SD);
  endfunction

  function automatic logic [63:0] ref_load(mem_op_t op, int off, logic [63:0] dw);
    int n;
    logic [63:0] v;
    n = ref_bytes(op);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = dw[8*(off+i) +: 8];
    if ((op == OP_LB || op == OP_LH || op == OP_LW) && v[8*n-1])
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] ref_strb(mem_op_t op, int off);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < ref_bytes(op); i++) s[off+i] = 1'b1;
    return s;
  endfunction

  task automatic scramble_inputs();
    bus.in_op         = mem_op_t'(4'($urandom_range(0, 11)));
    bus.in_rd         = 5'($urandom);
    bus.in_result     = {$urandom, $urandom};
    bus.in_store_data = {$urandom, $urandom};
  endtask

  // Runs one op from acceptance to completion; entered and left on a negedge.
  task automatic do_op(input mem_op_t op, input logic [4:0] rd, input logic [63:0] addr,
                       input logic [63:0] sdata, input int rdy_dly, input int rsp_dly,
                       input logic [63:0] rdata);
    int          off;
    bit          ld, st, mis;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_strb;
    off = int'(addr[2:0]);
    ld  = ref_is_load(op);
    st  = ref_is_store(op);
    mis = (ld || st) && ((off % ref_bytes(op)) != 0);
    exp_wdata = st ? (sdata << (8*off)) : 64'd0;
    exp_strb  = st ? ref_strb(op, off) : 8'd0;

    chk1("in_ready_before_accept", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_rd = rd;
    bus.in_result = addr;
    bus.in_store_data = sdata;
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble_inputs();

    if (mis) begin
      chk1("misalign_pulse", bus.misalign_err, 1'b1);
      chk1("misalign_no_req", bus.mem_req_valid, 1'b0);
      chk1("misalign_no_wb", bus.wb_valid, 1'b0);
      chk1("misalign_ready", bus.in_ready, 1'b1);
      @(negedge clk);
      chk1("misalign_one_cycle", bus.misalign_err, 1'b0);
      chk1("misalign_no_req_later", bus.mem_req_valid, 1'b0);
      return;
    end

    if (!ld && !st) begin
      chk1("none_wb_valid", bus.wb_valid, rd != 5'd0);
      chk64("none_wb_rd", 64'(bus.wb_rd), 64'(rd));
      if (rd != 5'd0) chk64("none_wb_data", bus.wb_data, addr);
      chk1("none_busy", bus.in_ready, 1'b0);
      chk1("none_no_req", bus.mem_req_valid, 1'b0);
      @(negedge clk);
      chk1("none_wb_once", bus.wb_valid, 1'b0);
      chk1("none_ready_back", bus.in_ready, 1'b1);
      return;
    end

    for (int c = 0; c <= rdy_dly; c++) begin
      chk1("req_valid", bus.mem_req_valid, 1'b1);
      chk64("req_addr", bus.mem_req_addr, {addr[63:3], 3'b000});
      chk1("req_we", bus.mem_req_we, st);
      chk64("req_wdata", bus.mem_req_wdata, exp_wdata);
      chk64("req_strb", 64'(bus.mem_req_strb), 64'(exp_strb));
      chk1("req_busy", bus.in_ready, 1'b0);
      chk1("req_no_wb", bus.wb_valid, 1'b0);
      bus.mem_req_ready = (c == rdy_dly);
      bus.mem_rsp_valid = (c != rdy_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.mem_rsp_data  = {$urandom, $urandom};
      @(negedge clk);
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;

    if (st) begin
      chk1("store_req_drop", bus.mem_req_valid, 1'b0);
      chk64("store_addr_zero", bus.mem_req_addr, 64'd0);
      chk1("store_no_wb", bus.wb_valid, 1'b0);
      chk1("store_ready_back", bus.in_ready, 1'b1);
      return;
    end

    for (int c = 0; c < rsp_dly; c++) begin
      chk1("resp_no_req", bus.mem_req_valid, 1'b0);
      chk1("resp_no_wb", bus.wb_valid, 1'b0);
      chk1("resp_busy", bus.in_ready, 1'b0);
      @(negedge clk);
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = rdata;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = {$urandom, $urandom};
    chk1("load_wb_valid", bus.wb_valid, rd != 5'd0);
    chk64("load_wb_rd", 64'(bus.wb_rd), 64'(rd));
    if (rd != 5'd0) chk64("load_wb_data", bus.wb_data, ref_load(op, off, rdata));
    chk1("load_wb_busy", bus.in_ready, 1'b0);
    @(negedge clk);
    chk1("load_wb_once", bus.wb_valid, 1'b0);
    chk1("load_ready_back", bus.in_ready, 1'b1);
  endtask

  initial begin
    mem_op_t     rop;
    logic [63:0] raddr;
    bus.in_valid      = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    scramble_inputs();

    #2;
    chk1("rst_req_valid", bus.mem_req_valid, 1'b0);
    chk1("rst_wb_valid", bus.wb_valid, 1'b0);
    chk1("rst_misalign", bus.misalign_err, 1'b0);
    chk64("rst_req_addr", bus.mem_req_addr, 64'd0);
    chk64("rst_wb_data", bus.wb_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_op(OP_NONE, 5'd5, 64'h1234, 64'd0, 0, 0, 64'd0);
    do_op(OP_LB,  5'd1, 64'h1003, 64'd0, 0, 0, 64'h0000_0000_8000_0000);
    do_op(OP_LBU, 5'd2, 64'h1003, 64'd0, 0, 0, 64'h0000_0000_8000_0000);
    do_op(OP_SH,  5'd3, 64'h2006, 64'hBEEF, 0, 0, 64'd0);
    do_op(OP_LW,  5'd4, 64'h3002, 64'd0, 0, 0, 64'd0);
    do_op(OP_LD,  5'd6, 64'h5008, 64'd0, 3, 2, 64'h0123_4567_89AB_CDEF);
    do_op(OP_LH,  5'd0, 64'h6006, 64'd0, 1, 1, 64'h8001_0000_0000_0000);
    do_op(OP_LWU, 5'd7, 64'h7004, 64'd0, 0, 0, 64'hF00D_CAFE_0000_0000);

    // Reset while the request is still outstanding.
    bus.in_valid = 1'b1;
    bus.in_op = OP_SD;
    bus.in_rd = 5'd9;
    bus.in_result = 64'h8000;
    bus.in_store_data = 64'h55;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk1("abort_req_pre", bus.mem_req_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("abort_req_valid", bus.mem_req_valid, 1'b0);
    chk64("abort_req_addr", bus.mem_req_addr, 64'd0);
    chk64("abort_req_wdata", bus.mem_req_wdata, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk1("abort_req_ready", bus.in_ready, 1'b1);

    // Reset while waiting for a load response, then a stale response.
    bus.in_valid = 1'b1;
    bus.in_op = OP_LD;
    bus.in_rd = 5'd7;
    bus.in_result = 64'h4000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk1("abort_resp_busy", bus.in_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk1("abort_resp_wb", bus.wb_valid, 1'b0);
    chk1("abort_resp_req", bus.mem_req_valid, 1'b0);
    chk64("abort_resp_wb_data", bus.wb_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk1("abort_resp_ready", bus.in_ready, 1'b1);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    chk1("stale_rsp_no_wb", bus.wb_valid, 1'b0);
    @(negedge clk);
    chk1("stale_rsp_no_wb2", bus.wb_valid, 1'b0);
    do_op(OP_LW, 5'd8, 64'h9004, 64'd0, 1, 0, 64'h8765_4321_0000_0000);

    for (int k = 0; k < 300; k++) begin
      rop   = mem_op_t'(4'($urandom_range(0, 11)));
      raddr = {$urandom, $urandom};
      do_op(rop, 5'($urandom), raddr, {$urandom, $urandom},
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
